// File: rtl/power_sequencer.sv
// Power sequencer for the ToF sensor front end: supply -> clock -> reset release -> ready,
// reverse order on power-down, and an immediate all-off with a sticky fault on supply loss.
module power_sequencer #(
  parameter int T_SUPPLY      = 1000,
  parameter int PGOOD_TIMEOUT = 50000,
  parameter int T_CLK         = 100,
  parameter int T_RST         = 1000,
  parameter int T_OFF         = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pgood,
  output logic       supply_en,
  output logic       sensor_clk_en,
  output logic       sensor_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam int MAX_A = (T_SUPPLY > PGOOD_TIMEOUT) ? T_SUPPLY : PGOOD_TIMEOUT;
  localparam int MAX_B = (T_CLK > T_RST) ? T_CLK : T_RST;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP  = (MAX_C > T_OFF) ? MAX_C : T_OFF;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  // Each wait leaves on the edge where cnt equals its length minus one.
  localparam logic [CW-1:0] SUP_LAST = CW'(T_SUPPLY - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(PGOOD_TIMEOUT - 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(T_CLK - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(T_RST - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);

  typedef enum logic [2:0] {
    S_OFF         = 3'd0,
    S_SUPPLY_WAIT = 3'd1,
    S_CLK_WAIT    = 3'd2,
    S_RST_WAIT    = 3'd3,
    S_READY       = 3'd4,
    S_PD_RST      = 3'd5,
    S_PD_CLK      = 3'd6,
    S_FAULT       = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          supply_en_q, supply_en_d;
  logic          clk_en_q, clk_en_d;
  logic          rst_n_q, rst_n_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  // Priority in every powered state: pgood loss, then en=0, then timer expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF: begin
        if (en) state_d = S_SUPPLY_WAIT;
      end
      S_SUPPLY_WAIT: begin
        if (!en)                                state_d = S_PD_CLK;
        else if (cnt_q >= SUP_LAST && pgood)    state_d = S_CLK_WAIT;
        else if (cnt_q == TMO_LAST)             state_d = S_FAULT;
      end
      S_CLK_WAIT: begin
        if (!pgood)                 state_d = S_FAULT;
        else if (!en)               state_d = S_PD_RST;
        else if (cnt_q == CLK_LAST) state_d = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        if (!pgood)                 state_d = S_FAULT;
        else if (!en)               state_d = S_PD_RST;
        else if (cnt_q == RST_LAST) state_d = S_READY;
      end
      S_READY: begin
        if (!pgood)   state_d = S_FAULT;
        else if (!en) state_d = S_PD_RST;
      end
      // en is deliberately ignored here so a started power-down always completes.
      S_PD_RST: begin
        if (!pgood)                 state_d = S_FAULT;
        else if (cnt_q == OFF_LAST) state_d = S_PD_CLK;
      end
      S_PD_CLK: begin
        if (!pgood)                 state_d = S_FAULT;
        else if (cnt_q == OFF_LAST) state_d = S_OFF;
      end
      S_FAULT: begin
        if (!en) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    supply_en_d = 1'b0;
    clk_en_d    = 1'b0;
    rst_n_d     = 1'b0;
    ready_d     = 1'b0;
    fault_d     = 1'b0;
    unique case (state_d)
      S_OFF: ;
      S_SUPPLY_WAIT: supply_en_d = 1'b1;
      S_CLK_WAIT: begin
        supply_en_d = 1'b1;
        clk_en_d    = 1'b1;
      end
      S_RST_WAIT: begin
        supply_en_d = 1'b1;
        clk_en_d    = 1'b1;
        rst_n_d     = 1'b1;
      end
      S_READY: begin
        supply_en_d = 1'b1;
        clk_en_d    = 1'b1;
        rst_n_d     = 1'b1;
        ready_d     = 1'b1;
      end
      S_PD_RST: begin
        supply_en_d = 1'b1;
        clk_en_d    = 1'b1;
      end
      S_PD_CLK: supply_en_d = 1'b1;
      S_FAULT:  fault_d     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      supply_en_q <= 1'b0;
      clk_en_q    <= 1'b0;
      rst_n_q     <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      supply_en_q <= supply_en_d;
      clk_en_q    <= clk_en_d;
      rst_n_q     <= rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign supply_en     = supply_en_q;
  assign sensor_clk_en = clk_en_q;
  assign sensor_rst_n  = rst_n_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign state         = state_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer: per-edge expected output vectors are queued by the
// driver and compared by an independent monitor half a cycle after each rising edge.
module tb_power_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       pgood;
  logic       supply_en;
  logic       sensor_clk_en;
  logic       sensor_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;

  power_sequencer #(
    .T_SUPPLY(4), .PGOOD_TIMEOUT(6), .T_CLK(3), .T_RST(2), .T_OFF(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pgood(pgood),
    .supply_en(supply_en), .sensor_clk_en(sensor_clk_en),
    .sensor_rst_n(sensor_rst_n), .ready(ready), .fault(fault), .state(state)
  );

  // Vector layout: {state[2:0], supply_en, sensor_clk_en, sensor_rst_n, ready, fault}
  localparam logic [7:0] V_OFF = 8'b000_00000;
  localparam logic [7:0] V_SW  = 8'b001_10000;
  localparam logic [7:0] V_CW  = 8'b010_11000;
  localparam logic [7:0] V_RW  = 8'b011_11100;
  localparam logic [7:0] V_RDY = 8'b100_11110;
  localparam logic [7:0] V_PDR = 8'b101_11000;
  localparam logic [7:0] V_PDC = 8'b110_10000;
  localparam logic [7:0] V_FLT = 8'b111_00001;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs applied just after an edge, expected result queued at the next edge
  task automatic hold(input int n, input logic e, input logic p, input logic [7:0] v,
                      input string name);
    for (int i = 0; i < n; i++) begin
      en    = e;
      pgood = p;
      @(posedge clk);
      exp_q.push_back(v);
      tag_q.push_back(name);
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(posedge clk);
    exp_q.push_back(V_OFF);
    tag_q.push_back(name);
    #1;
    rst = 1'b0;
  endtask

  task automatic bring_up(input string name);
    hold(4, 1'b1, 1'b1, V_SW, {name, "_sw"});
    hold(3, 1'b1, 1'b1, V_CW, {name, "_cw"});
    hold(2, 1'b1, 1'b1, V_RW, {name, "_rw"});
    hold(1, 1'b1, 1'b1, V_RDY, {name, "_rdy"});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] obs;
      logic [7:0] exp_v;
      string      name;
      obs   = {state, supply_en, sensor_clk_en, sensor_rst_n, ready, fault};
      exp_v = exp_q.pop_front();
      name  = tag_q.pop_front();
      n_checks++;
      if (obs !== exp_v) begin
        n_errors++;
        $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                 name, obs[7:5], obs[4:0], exp_v[7:5], exp_v[4:0]);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    pgood = 1'b0;
    do_reset("reset");
    hold(1, 1'b0, 1'b1, V_OFF, "off_idle");

    // Bring-up timing and ready hold
    bring_up("up1");
    hold(2, 1'b1, 1'b1, V_RDY, "ready_hold");

    // Orderly power-down
    hold(2, 1'b0, 1'b1, V_PDR, "pd_rst");
    hold(2, 1'b0, 1'b1, V_PDC, "pd_clk");
    hold(2, 1'b0, 1'b1, V_OFF, "pd_off");

    // pgood timeout; pgood is ignored in FAULT and OFF
    hold(6, 1'b1, 1'b0, V_SW, "tmo_sw");
    hold(3, 1'b1, 1'b0, V_FLT, "tmo_fault");
    hold(2, 1'b0, 1'b0, V_OFF, "tmo_clear");

    // One-cycle pgood glitch in READY latches the fault
    bring_up("up2");
    hold(1, 1'b1, 1'b0, V_FLT, "glitch_fault");
    hold(3, 1'b1, 1'b1, V_FLT, "glitch_sticky");
    hold(1, 1'b0, 1'b1, V_OFF, "glitch_clear");

    // en re-asserted during PD_CLK, then supply abort from SUPPLY_WAIT
    bring_up("up3");
    hold(2, 1'b0, 1'b1, V_PDR, "reen_pdr");
    hold(1, 1'b0, 1'b1, V_PDC, "reen_pdc0");
    hold(1, 1'b1, 1'b1, V_PDC, "reen_pdc1");
    hold(1, 1'b1, 1'b1, V_OFF, "reen_off");
    hold(1, 1'b1, 1'b1, V_SW, "reen_restart");
    hold(2, 1'b0, 1'b1, V_PDC, "abort_pdc");
    hold(1, 1'b0, 1'b1, V_OFF, "abort_off");

    // en dropped in CLK_WAIT
    hold(4, 1'b1, 1'b1, V_SW, "cwabort_sw");
    hold(1, 1'b1, 1'b1, V_CW, "cwabort_cw");
    hold(2, 1'b0, 1'b1, V_PDR, "cwabort_pdr");
    hold(2, 1'b0, 1'b1, V_PDC, "cwabort_pdc");
    hold(1, 1'b0, 1'b1, V_OFF, "cwabort_off");

    // Reset mid-sequence, then late pgood accepted on the last timeout cycle
    hold(4, 1'b1, 1'b1, V_SW, "mid_sw");
    hold(3, 1'b1, 1'b1, V_CW, "mid_cw");
    hold(1, 1'b1, 1'b1, V_RW, "mid_rw");
    do_reset("mid_reset");
    hold(6, 1'b1, 1'b0, V_SW, "late_sw");
    hold(1, 1'b1, 1'b1, V_CW, "late_cw_entry");
    hold(2, 1'b1, 1'b1, V_CW, "late_cw");
    hold(1, 1'b1, 1'b1, V_RW, "late_rw");

    // pgood loss wins over en=0
    hold(1, 1'b0, 1'b0, V_FLT, "prio_fault");
    hold(1, 1'b0, 1'b0, V_OFF, "prio_off");

    // Drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
